// File: rtl/psum_readout_serializer_if.sv
// Load/readout handshake bundle for psum_readout_serializer.
// slave = the serializer, master = upstream capture regs plus downstream writeback path.
interface psum_readout_serializer_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDXW = (LANES > 1) ? $clog2(LANES) : 1;

  logic                   load_valid;
  logic                   load_ready;
  logic [LANES*WIDTH-1:0] load_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [IDXW-1:0]        out_lane_idx;
  logic                   out_last;

  modport master (
    output load_valid, load_data, out_ready,
    input  load_ready, out_valid, out_data, out_lane_idx, out_last
  );

  modport slave (
    input  load_valid, load_data, out_ready,
    output load_ready, out_valid, out_data, out_lane_idx, out_last
  );
endinterface

// File: rtl/psum_readout_serializer.sv
// Shadows one LANES-wide psum word and streams it out one lane per beat.
// Optional macro READOUT_PREFETCH_EN: accept the next word on the final beat (no idle bubble).
module psum_readout_serializer #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDXW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  psum_readout_serializer_if.slave  bus,
  output logic                      busy
);

  typedef enum logic {StIdle, StSend} state_e;

  localparam logic [IDXW-1:0] LastIdx = IDXW'(LANES - 1);

  state_e                 state_q;
  logic [IDXW-1:0]        cnt_q;
  logic [LANES*WIDTH-1:0] shadow_q;
  logic                   out_valid_q;
  logic [WIDTH-1:0]       out_data_q;
  logic [IDXW-1:0]        out_idx_q;
  logic                   out_last_q;

  logic                   load_ready;
  logic                   load_fire;
  logic                   out_fire;
  logic [IDXW-1:0]        nxt_idx;
  logic [WIDTH-1:0]       nxt_lane;

`ifdef READOUT_PREFETCH_EN
  // The only input-to-output path: ready opens while the final beat is being taken.
  assign load_ready = (state_q == StIdle) ||
                      ((state_q == StSend) && out_last_q && bus.out_ready);
`else
  assign load_ready = (state_q == StIdle);
`endif

  assign load_fire = bus.load_valid && load_ready;
  assign out_fire  = out_valid_q && bus.out_ready;
  assign nxt_idx   = cnt_q + 1'b1;

  always_comb begin
    nxt_lane = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (nxt_idx == IDXW'(i)) nxt_lane = shadow_q[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shadow_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else if (load_fire) begin
      // Outputs are registered, so lane 0 is presented straight from the incoming word.
      state_q     <= StSend;
      cnt_q       <= '0;
      shadow_q    <= bus.load_data;
      out_valid_q <= 1'b1;
      out_data_q  <= bus.load_data[WIDTH-1:0];
      out_idx_q   <= '0;
      out_last_q  <= (LANES == 1);
    end else if (out_fire) begin
      if (out_last_q) begin
        state_q     <= StIdle;
        cnt_q       <= '0;
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        out_idx_q   <= '0;
        out_last_q  <= 1'b0;
      end else begin
        cnt_q      <= nxt_idx;
        out_data_q <= nxt_lane;
        out_idx_q  <= nxt_idx;
        out_last_q <= (nxt_idx == LastIdx);
      end
    end
  end

  assign bus.load_ready   = load_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_lane_idx = out_idx_q;
  assign bus.out_last     = out_last_q;
  assign busy             = (state_q == StSend);

endmodule
